// File: rtl/emu_step_transactor.sv
// Host-controlled step transactor: stimulus/capture banks plus an N-step generated DUT clock burst.
module emu_step_transactor #(
    parameter int unsigned NUM_STIM = 2,
    parameter int unsigned NUM_OUT  = 2,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                  clk_emu,
    input  logic                  reset_n,
    input  logic [7:0]            Din_emu,
    output logic [7:0]            Dout_emu,
    input  logic [ADDR_W-1:0]     Addr_emu,
    input  logic                  wr_emu,
    input  logic                  load_emu,
    input  logic                  get_emu,
    input  logic                  run_emu,
    output logic [8*NUM_STIM-1:0] stim_out,
    input  logic [8*NUM_OUT-1:0]  dut_out,
    output logic                  clk_dut,
    output logic                  busy_emu
);

    localparam int unsigned STIM_W = 8 * NUM_STIM;
    localparam int unsigned OUT_W  = 8 * NUM_OUT;
    localparam int unsigned CNT_W  = 9;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        CAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [STIM_W-1:0]  shadow_q;
    logic [OUT_W-1:0]   capture_q;
    logic [7:0]         steps_q;
    logic               done_q;
    logic               changed_q;
    logic               start_c;
    logic               capture_c;
    logic               load_c;
    logic               ctrl_wr_c;
    logic [7:0]         rd_data_c;

    // Next-state and burst control
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        start_c     = 1'b0;
        capture_c   = 1'b0;
        load_c      = 1'b0;
        ctrl_wr_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                load_c    = load_emu;
                capture_c = get_emu && !load_emu;
                ctrl_wr_c = wr_emu && (Addr_emu == CTRL_ADDR);
                if (run_emu) begin
                    start_c     = 1'b1;
                    state_d     = HIGH;
                    remaining_d = (steps_q == 8'd0) ? CNT_W'(256) : {1'b0, steps_q};
                end
            end
            HIGH: state_d = LOW;
            LOW: begin
                remaining_d = remaining_q - CNT_W'(1);
                state_d     = (remaining_q == CNT_W'(1)) ? CAP : HIGH;
            end
            CAP: begin
                capture_c = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Host read mux; CTRL checked last so it wins any overlap
    always_comb begin
        rd_data_c = 8'h00;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (Addr_emu == ADDR_W'(k)) rd_data_c = capture_q[8*k +: 8];
        end
        if (Addr_emu == CTRL_ADDR) rd_data_c = {busy_emu, done_q, changed_q, 5'b0};
    end

    // FSM state, step counter and registered clock/busy outputs
    always_ff @(posedge clk_emu or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            clk_dut     <= 1'b0;
            busy_emu    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            clk_dut     <= (state_d == HIGH);
            busy_emu    <= (state_d != IDLE);
        end
    end

    // Host-visible banks, step count and status
    always_ff @(posedge clk_emu or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q  <= '0;
            stim_out  <= '0;
            capture_q <= '0;
            steps_q   <= 8'd1;
            done_q    <= 1'b0;
            changed_q <= 1'b0;
            Dout_emu  <= 8'h00;
        end else begin
            Dout_emu <= rd_data_c;
            for (int unsigned k = 0; k < NUM_STIM; k++) begin
                if (wr_emu && (Addr_emu == ADDR_W'(k))) shadow_q[8*k +: 8] <= Din_emu;
            end
            if (ctrl_wr_c) steps_q <= Din_emu;
            if (load_c) stim_out <= shadow_q;
            if (start_c) done_q <= 1'b0;
            if (capture_c) begin
                capture_q <= dut_out;
                changed_q <= (dut_out != capture_q);
            end
            if (state_q == CAP) done_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_emu_step_transactor.sv
// Self-checking bench for emu_step_transactor: host reads are scored against a queue of expected bytes.
module tb_emu_step_transactor;

    localparam int unsigned NUM_STIM = 2;
    localparam int unsigned NUM_OUT  = 2;
    localparam int unsigned ADDR_W   = 4;
    localparam logic [ADDR_W-1:0] CTRL = 4'hF;

    logic                  clk_emu = 1'b0;
    logic                  reset_n;
    logic [7:0]            Din_emu;
    logic [7:0]            Dout_emu;
    logic [ADDR_W-1:0]     Addr_emu;
    logic                  wr_emu, load_emu, get_emu, run_emu;
    logic [8*NUM_STIM-1:0] stim_out;
    logic [8*NUM_OUT-1:0]  dut_out;
    logic                  clk_dut;
    logic                  busy_emu;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        pulses   = 0;
    int        busy_cyc = 0;
    logic [7:0] exp_q[$];

    emu_step_transactor #(
        .NUM_STIM(NUM_STIM),
        .NUM_OUT (NUM_OUT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk_emu (clk_emu),
        .reset_n (reset_n),
        .Din_emu (Din_emu),
        .Dout_emu(Dout_emu),
        .Addr_emu(Addr_emu),
        .wr_emu  (wr_emu),
        .load_emu(load_emu),
        .get_emu (get_emu),
        .run_emu (run_emu),
        .stim_out(stim_out),
        .dut_out (dut_out),
        .clk_dut (clk_dut),
        .busy_emu(busy_emu)
    );

    always #5 clk_emu = ~clk_emu;

    always @(posedge clk_dut) pulses++;
    always @(negedge clk_emu) if (busy_emu) busy_cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(posedge clk_emu); #1;
        Addr_emu = a; Din_emu = d; wr_emu = 1'b1;
        @(posedge clk_emu); #1;
        wr_emu = 1'b0;
    endtask

    task automatic host_rd(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        logic [7:0] e;
        @(posedge clk_emu); #1;
        Addr_emu = a;
        exp_q.push_back(exp);
        @(posedge clk_emu); #1;
        e = exp_q.pop_front();
        check(tag, 32'(Dout_emu), 32'(e));
    endtask

    // which: 0 load, 1 get, 2 run, 3 load+get
    task automatic pulse(input int which);
        @(posedge clk_emu); #1;
        load_emu = (which == 0) || (which == 3);
        get_emu  = (which == 1) || (which == 3);
        run_emu  = (which == 2);
        @(posedge clk_emu); #1;
        load_emu = 1'b0; get_emu = 1'b0; run_emu = 1'b0;
    endtask

    task automatic start_burst();
        pulses = 0; busy_cyc = 0;
        pulse(2);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk_emu);
            if (!busy_emu) break;
        end
        if (k == 2000) check({tag, "_timeout"}, 32'(busy_emu), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; Din_emu = '0; Addr_emu = '0;
        wr_emu = 1'b0; load_emu = 1'b0; get_emu = 1'b0; run_emu = 1'b0;
        dut_out = 16'hBEEF;
        #23 reset_n = 1'b1;

        // Reset state
        @(negedge clk_emu);
        check("rst_stim", 32'(stim_out), 32'h0);
        check("rst_clk_dut", 32'(clk_dut), 32'h0);
        check("rst_busy", 32'(busy_emu), 32'h0);
        check("rst_dout", 32'(Dout_emu), 32'h0);
        host_rd("rst_status", CTRL, 8'h00);
        host_rd("rst_cap0", 4'd0, 8'h00);

        // Shadow write does not reach stim_out until load
        host_wr(4'd0, 8'hA5);
        check("shadow_no_leak", 32'(stim_out), 32'h0);
        host_wr(4'd1, 8'h3C);
        check("shadow_no_leak2", 32'(stim_out), 32'h0);
        pulse(0);
        check("load_stim", 32'(stim_out), 32'h3CA5);

        // Three-step burst
        host_wr(CTRL, 8'd3);
        start_burst();
        wait_idle("burst3");
        check("burst3_pulses", 32'(pulses), 32'd3);
        check("burst3_busy", 32'(busy_cyc), 32'd7);
        host_rd("burst3_status", CTRL, 8'h60);
        host_rd("burst3_cap0", 4'd0, 8'hEF);
        host_rd("burst3_cap1", 4'd1, 8'hBE);
        host_rd("unmapped_rd", 4'd5, 8'h00);

        // get with identical data clears changed, done stays
        pulse(1);
        host_rd("get_same_status", CTRL, 8'h40);

        // Commands during a burst are ignored; shadow writes still land
        host_wr(CTRL, 8'd6);
        start_burst();
        dut_out = 16'h1111;
        pulse(0);
        pulse(1);
        pulse(2);
        host_wr(CTRL, 8'd9);
        host_wr(4'd0, 8'h77);
        check("busy_mid", 32'(busy_emu), 32'd1);
        check("stim_hold_busy", 32'(stim_out), 32'h3CA5);
        wait_idle("burst6");
        check("burst6_pulses", 32'(pulses), 32'd6);
        check("burst6_busy", 32'(busy_cyc), 32'd13);
        check("stim_after_busy", 32'(stim_out), 32'h3CA5);
        host_rd("burst6_status", CTRL, 8'h60);
        host_rd("burst6_cap0", 4'd0, 8'h11);
        pulse(0);
        check("late_load", 32'(stim_out), 32'h3C77);
        start_burst();
        wait_idle("steps_kept");
        check("steps_kept_pulses", 32'(pulses), 32'd6);

        // load and get together: load only
        dut_out = 16'h1234;
        host_wr(4'd0, 8'h99);
        pulse(3);
        check("loadget_stim", 32'(stim_out), 32'h3C99);
        host_rd("loadget_cap0", 4'd0, 8'h11);
        host_rd("loadget_cap1", 4'd1, 8'h11);

        // STEPS=0 means 256 steps
        host_wr(CTRL, 8'd0);
        start_burst();
        wait_idle("burst256");
        check("burst256_pulses", 32'(pulses), 32'd256);
        check("burst256_busy", 32'(busy_cyc), 32'd513);
        host_rd("burst256_status", CTRL, 8'h60);
        host_rd("burst256_cap1", 4'd1, 8'h12);

        // Reset mid-burst aborts immediately
        host_wr(CTRL, 8'd5);
        start_burst();
        for (int k = 0; k < 100 && pulses < 2; k++) @(negedge clk_emu);
        check("abort_reached2", 32'(pulses), 32'd2);
        reset_n = 1'b0;
        #1;
        check("abort_clk_dut", 32'(clk_dut), 32'd0);
        check("abort_busy", 32'(busy_emu), 32'd0);
        check("abort_stim", 32'(stim_out), 32'h0);
        check("abort_dout", 32'(Dout_emu), 32'h0);
        @(negedge clk_emu);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_emu);
        check("abort_no_more_pulses", 32'(pulses), 32'd2);
        host_rd("abort_status", CTRL, 8'h00);
        host_rd("abort_cap0", 4'd0, 8'h00);
        host_rd("abort_cap1", 4'd1, 8'h00);

        // Reset restores STEPS=1
        start_burst();
        wait_idle("steps_default");
        check("steps_default_pulses", 32'(pulses), 32'd1);
        check("steps_default_busy", 32'(busy_cyc), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
